// File: rtl/umi_putc_pkg.sv
// Shared opcode, address and TX state definitions for the UMI putc UART sink.
// Pure declarations: no latency and no backpressure of their own.
package umi_putc_pkg;

  localparam logic [4:0]  UMI_REQ_POSTED    = 5'h05;
  localparam logic [63:0] PUTC_ADDR_DEFAULT = 64'h0000_0000_0100_0000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic is_putc(input logic [4:0] opcode, input logic addr_hit);
    return (opcode == UMI_REQ_POSTED) && addr_hit;
  endfunction

endpackage

// File: rtl/umi_putc_fifo.sv
// First-word-fall-through FIFO: o_dat is valid in the same cycle that o_empty is low.
// One cycle from push to visible; a push while full or a pop while empty is ignored.
module umi_putc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dat   = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_dat;
  end

endmodule

// File: rtl/umi_putc_uart.sv
// UMI posted-write sink that prints the low data byte of PUTC writes on an 8N1 UART line.
// Line falls one cycle after the handshake; ready drops only while the buffer is full, stray requests are dropped.
module umi_putc_uart
  import umi_putc_pkg::*;
#(
  parameter int                    CMD_WIDTH    = 32,
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 128,
  parameter logic [ADDR_WIDTH-1:0] PUTC_ADDR    = ADDR_WIDTH'(PUTC_ADDR_DEFAULT),
  parameter int                    FIFO_DEPTH   = 8,
  parameter int                    CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  udev_req_valid,
  input  logic [CMD_WIDTH-1:0]  udev_req_cmd,
  input  logic [ADDR_WIDTH-1:0] udev_req_dstaddr,
  input  logic [ADDR_WIDTH-1:0] udev_req_srcaddr,
  input  logic [DATA_WIDTH-1:0] udev_req_data,
  output logic                  udev_req_ready,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic [15:0]           drop_count
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic [15:0]       r_drop;

  logic              w_hs;
  logic              w_match;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [7:0]        w_fifo_dat;
  logic              w_baud_end;
  logic              w_unused_bits;

  assign w_unused_bits = ^{udev_req_srcaddr, udev_req_cmd[CMD_WIDTH-1:5],
                           udev_req_data[DATA_WIDTH-1:8]};

  assign udev_req_ready = !w_full;
  assign w_hs           = udev_req_valid && udev_req_ready;
  assign w_match        = is_putc(udev_req_cmd[4:0], udev_req_dstaddr == PUTC_ADDR);
  assign w_push         = w_hs && w_match;

  assign w_baud_end = (r_baud == BAUD_LAST);
  // Pop at frame start: from IDLE, or at the last stop-bit cycle for back-to-back frames.
  assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));

  assign uart_tx    = r_tx;
  assign tx_busy    = (r_state != IDLE) || !w_empty;
  assign drop_count = r_drop;

  umi_putc_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .i_push  (w_push),
    .i_dat   (udev_req_data[7:0]),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_dat),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_drop <= '0;
    end else if (w_hs && !w_match && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (!w_empty) begin
            r_shift <= w_fifo_dat;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (!w_empty) begin
              r_shift <= w_fifo_dat;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/umi_putc_uart.md
# umi_putc_uart

Downstream sink for character-print traffic on the emulation UMI bus. It accepts UMI posted writes addressed to the PUTC address and buffers the low data byte of each in a small FIFO. A TX state machine serializes the buffered bytes onto an 8N1 UART line. All other requests are accepted and discarded so the bus never stalls on stray traffic.

## Interface

Parameters:
- CMD_WIDTH, 32, UMI command width
- ADDR_WIDTH, 64, UMI address width
- DATA_WIDTH, 128, UMI data width
- PUTC_ADDR, 64'h1000000, address whose posted writes are printed
- FIFO_DEPTH, 8, character buffer depth; power of 2, ≥2
- CLKS_PER_BIT, 16, clk cycles per UART bit; ≥2

Ports:
- clk  in  1  sole clock
- nreset  in  1  reset; asynchronous, active-low
- udev_req_valid  in  1  request valid
- udev_req_cmd  in  CMD_WIDTH  UMI command; opcode in [4:0]
- udev_req_dstaddr  in  ADDR_WIDTH  destination address
- udev_req_srcaddr  in  ADDR_WIDTH  ignored (posted writes carry no response)
- udev_req_data  in  DATA_WIDTH  payload; only [7:0] used
- udev_req_ready  out  1  request ready
- uart_tx  out  1  serial line, idle high, registered
- tx_busy  out  1  FIFO non-empty or frame in flight
- drop_count  out  16  count of discarded requests, saturating

## Operation

- The handshake completes on a rising edge with valid && ready. udev_req_ready = !fifo_full. It does not depend on valid, cmd or address.
- A request matches when cmd[4:0] == 5'h05 (posted write) and dstaddr == PUTC_ADDR, compared at full width.
- A matched handshake pushes data[7:0] into the FIFO.
- An unmatched handshake is accepted and dropped; drop_count increments and holds at 16'hFFFF.
- FIFO: synchronous, first-word fall-through. Occupancy counter is clog2(FIFO_DEPTH)+1 bits. A push and a pop in the same cycle leave the count unchanged. Push never occurs when full because ready is low.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1) drive it.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop into the shift register, drive uart_tx=0 and go to START.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
  - DATA: send LSB first, each bit for CLKS_PER_BIT cycles. After bit 7, go to STOP and drive 1.
  - STOP: hold for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- tx_busy = (state != IDLE) || !fifo_empty.
- Reset values: uart_tx=1, state IDLE, FIFO empty, drop_count=0, tx_busy=0, udev_req_ready=1 (combinational from empty FIFO).
- Reset mid-frame aborts immediately. uart_tx returns high asynchronously, and queued bytes are discarded.

## Timing

- Latency: handshake at edge E with FIFO empty and TX idle gives uart_tx low from edge E+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- The ready fall is visible the cycle after the push that fills the FIFO. Ready rises the cycle after the pop that frees an entry.
- Simultaneous push and pop on a full FIFO cannot occur. On a FIFO with one entry, a simultaneous push and pop leaves one entry.
- Throughput is one byte per 10*CLKS_PER_BIT cycles. Upstream is back-pressured, never dropped.

## Structure

- Package umi_putc_pkg holds:
  - UMI_REQ_POSTED = 5'h05
  - default PUTC_ADDR
  - TX state enum {IDLE, START, DATA, STOP}
- Sub-module umi_putc_fifo: parameterized synchronous FIFO with push/pop/full/empty/data. It is instantiated once for the character buffer.
- Decode, drop counter and TX FSM stay in the top module.

## Test plan

1. Reset with CLKS_PER_BIT=4. Expect uart_tx=1, udev_req_ready=1, tx_busy=0, drop_count=0. Hold 50 cycles: no transition on uart_tx.
2. Single posted write of data 8'h48 to 0x1000000. Expect uart_tx to fall one cycle after the handshake. Line sequence is 0,0,0,0,1,0,0,1,0,1, each bit 4 cycles. tx_busy drops after 40 cycles.
3. Stream "Hello World!\n" (13 bytes) with FIFO_DEPTH=8 and valid held high.
   - Ready deasserts while the FIFO is full.
   - All 13 bytes appear in order as contiguous frames over 520 cycles.
   - drop_count stays 0.
4. Posted write to 0x1000004, then cmd 5'h03 to 0x1000000. Both are accepted the same cycle they are presented. Expect no UART activity and drop_count=2.
5. Queue 3 bytes, assert nreset low during data bit 3 of the first frame. Expect uart_tx=1 without waiting for clk. After release: FIFO empty, no further frames, ready=1.
6. Force drop_count near saturation via 65,537 unmatched writes. Expect it to hold at 16'hFFFF with no wrap to 0.
